comma_word_aligner: RTL and testbench
=====================================

COMMA_WORD_ALIGNER -- requirements
Module: comma_word_aligner

Interface
REQ-001 The block SHALL have parameter W, default 10, meaning the code-group width in bits (W >= 4).
REQ-002 The block SHALL have parameter COMMA_P, default 10'b0011110101, meaning the K28.5 pattern for the first running disparity.
REQ-003 The block SHALL have parameter COMMA_N, default 10'b1100001010, meaning the K28.5 pattern for the opposite running disparity.
REQ-004 The block SHALL have parameter LOCK_CNT, default 3, meaning the number of consecutive aligned commas required to declare lock (1..15).
REQ-005 The block SHALL have parameter LOSS_CNT, default 4, meaning the number of consecutive misaligned commas that drops lock (1..15).
REQ-006 The block SHALL have port CLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit, with reset asynchronous and active-high.
REQ-008 The block SHALL have port INP, input, W bits, the unaligned parallel word, sampled every cycle.
REQ-009 The block SHALL have port DOUT, output, W bits, the aligned code group (registered).
REQ-010 The block SHALL have port DVALID, output, 1 bit, high when DOUT carries aligned data.
REQ-011 The block SHALL have port LOCK, output, 1 bit, high in state SYNC only.
REQ-012 The block SHALL have port COMMA_DET, output, 1 bit, pulsing high for one cycle when DOUT holds a comma at the locked offset.
REQ-013 The block SHALL have port ALIGN_OFS, output, clog2(W) bits, the current bit offset.

Function
REQ-014 The block SHALL register INP into PREV every cycle and form window = {PREV, INP} (2W bits, PREV in MSBs); candidate k (0..W-1) = window[2W-1-k -: W].
REQ-015 The block SHALL declare a candidate a comma when it equals COMMA_P (or COMMA_N, see Configuration).
REQ-016 The block SHALL implement FSM states HUNT, CHECK and SYNC.
REQ-017 In HUNT, when any candidate matches, the block SHALL take the lowest matching k at that edge: ALIGN_OFS<=k, good count<=1, state<=CHECK.
REQ-018 In CHECK, each comma at ALIGN_OFS SHALL increment the good count; on reaching LOCK_CNT, state<=SYNC; with LOCK_CNT=1, HUNT SHALL go directly to SYNC.
REQ-019 In CHECK, a comma at any other offset with none at ALIGN_OFS SHALL send state<=HUNT, clear the counters, and drop DVALID at that edge.
REQ-020 In SYNC, a misaligned-only comma SHALL increment the miss count; an aligned comma SHALL clear it; on the miss count reaching LOSS_CNT, state<=HUNT, LOCK<=0.
REQ-021 Non-comma words SHALL not change any counter in CHECK or SYNC.
REQ-022 When both aligned and misaligned candidates match in the same cycle, the aligned match SHALL win.
REQ-023 At each edge ending cycle n, DOUT SHALL be loaded with candidate(ALIGN_OFS in effect after that edge) of the window of cycle n, giving latency 1 cycle from INP to DOUT.
REQ-024 DVALID SHALL equal (next state != HUNT).
REQ-025 In HUNT, DOUT SHALL hold its previous value.
REQ-026 Counters SHALL saturate and never wrap.

Reset
REQ-027 While reset=1, the block SHALL asynchronously force DOUT=0, PREV=0, DVALID=0, LOCK=0, COMMA_DET=0, ALIGN_OFS=0, counters=0 and state=HUNT.
REQ-028 Reset asserted mid-SYNC SHALL drop LOCK immediately, without waiting for CLK.
REQ-029 After reset release, the first edge SHALL load PREV only.
REQ-030 After reset release, comma detection SHALL be valid from the second edge.

Configuration
REQ-031 With COMMA_BOTH_RD_EN defined, the block SHALL match both COMMA_P and COMMA_N.
REQ-032 Without COMMA_BOTH_RD_EN, the block SHALL match only COMMA_P.
REQ-033 Without COMMA_BOTH_RD_EN, a COMMA_N pattern SHALL be treated as ordinary data, and COMMA_N logic SHALL be absent from the netlist.

Verification
REQ-034 The bench SHALL drive reset 16 time units, INP=35 for 20 cycles -> required response: DVALID=0, LOCK=0, DOUT=0.
REQ-035 The bench SHALL drive 0011110101 repeated at offset 0, three times with data between -> required response: ALIGN_OFS=0, LOCK=1 on the third comma edge, COMMA_DET one-cycle pulses.
REQ-036 The bench SHALL drive a comma shifted by 3 bits across a word boundary -> required response: ALIGN_OFS=3, DOUT=0011110101 one edge later.
REQ-037 In SYNC, the bench SHALL inject 4 consecutive commas at offset 5 -> required response: LOCK falls at the fourth.
REQ-038 In SYNC, the bench SHALL inject 3 misaligned commas, 1 aligned and 3 misaligned -> required response: LOCK stays 1.
REQ-039 The bench SHALL drive 1100001010 at offset 0 -> required response: lock with COMMA_BOTH_RD_EN defined, and DVALID stays 0 without it.
REQ-040 The bench SHALL assert reset for 15 units mid-SYNC, then drive INP=35 -> required response: LOCK=0 asynchronously, and state HUNT until a fresh comma arrives.

Source files
------------

// File: rtl/comma_word_aligner.sv
// Comma word aligner: finds the K28.5 bit offset in an unaligned parallel stream and locks onto it.
// Build option: define COMMA_BOTH_RD_EN to also accept the opposite-disparity comma COMMA_N.
module comma_word_aligner #(
    parameter int unsigned  W        = 10,
    parameter logic [W-1:0] COMMA_P  = 10'b0011110101,
    parameter logic [W-1:0] COMMA_N  = 10'b1100001010,
    parameter int unsigned  LOCK_CNT = 3,
    parameter int unsigned  LOSS_CNT = 4
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [W-1:0]         INP,
    output logic [W-1:0]         DOUT,
    output logic                 DVALID,
    output logic                 LOCK,
    output logic                 COMMA_DET,
    output logic [$clog2(W)-1:0] ALIGN_OFS
);
    localparam int unsigned OW = $clog2(W);

    typedef enum logic [1:0] {HUNT, CHECK, SYNC} state_t;

    state_t         r_state, w_state_nx;
    logic [W-1:0]   r_prev;
    logic [W-1:0]   r_dout;
    logic           r_armed;
    logic           r_comma_det;
    logic [OW-1:0]  r_ofs, w_ofs_nx, w_low_ofs;
    logic [3:0]     r_good, r_miss;
    logic [3:0]     w_good_nx, w_miss_nx, w_good_inc, w_miss_inc;
    logic [2*W-1:0] w_window;
    logic [W-1:0]   w_cand [W];
    logic [W-1:0]   w_match;
    logic           w_any, w_aligned, w_misaligned;

    if (W < 4 || LOCK_CNT < 1 || LOCK_CNT > 15 || LOSS_CNT < 1 || LOSS_CNT > 15
        || COMMA_N == COMMA_P) begin : g_bad_params
        $error("comma_word_aligner: invalid parameter set");
    end

    assign w_window = {r_prev, INP};

    // r_armed masks the first edge after reset, when PREV still holds reset zeros.
    for (genvar g = 0; g < W; g++) begin : g_cand
        assign w_cand[g] = w_window[2*W-1-g -: W];
`ifdef COMMA_BOTH_RD_EN
        assign w_match[g] = r_armed && ((w_cand[g] == COMMA_P) || (w_cand[g] == COMMA_N));
`else
        assign w_match[g] = r_armed && (w_cand[g] == COMMA_P);
`endif
    end

    assign w_any        = |w_match;
    assign w_aligned    = w_match[r_ofs];
    assign w_misaligned = |(w_match & ~(W'(1) << r_ofs));
    assign w_good_inc   = (r_good == 4'hF) ? r_good : r_good + 4'd1;
    assign w_miss_inc   = (r_miss == 4'hF) ? r_miss : r_miss + 4'd1;

    always_comb begin
        w_low_ofs = '0;
        for (int unsigned k = W; k > 0; k--) begin
            if (w_match[OW'(k - 1)]) begin
                w_low_ofs = OW'(k - 1);
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ofs_nx   = r_ofs;
        w_good_nx  = r_good;
        w_miss_nx  = r_miss;
        case (r_state)
            HUNT: begin
                if (w_any) begin
                    w_ofs_nx   = w_low_ofs;
                    w_good_nx  = 4'd1;
                    w_miss_nx  = '0;
                    w_state_nx = (LOCK_CNT == 1) ? SYNC : CHECK;
                end
            end
            CHECK: begin
                if (w_aligned) begin
                    w_good_nx = w_good_inc;
                    if (w_good_inc >= 4'(LOCK_CNT)) begin
                        w_state_nx = SYNC;
                    end
                end else if (w_misaligned) begin
                    w_state_nx = HUNT;
                    w_good_nx  = '0;
                    w_miss_nx  = '0;
                end
            end
            SYNC: begin
                if (w_aligned) begin
                    w_miss_nx = '0;
                end else if (w_misaligned) begin
                    w_miss_nx = w_miss_inc;
                    if (w_miss_inc >= 4'(LOSS_CNT)) begin
                        w_state_nx = HUNT;
                        w_good_nx  = '0;
                        w_miss_nx  = '0;
                    end
                end
            end
            default: w_state_nx = HUNT;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state     <= HUNT;
            r_prev      <= '0;
            r_armed     <= 1'b0;
            r_ofs       <= '0;
            r_good      <= '0;
            r_miss      <= '0;
            r_dout      <= '0;
            r_comma_det <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_prev      <= INP;
            r_armed     <= 1'b1;
            r_ofs       <= w_ofs_nx;
            r_good      <= w_good_nx;
            r_miss      <= w_miss_nx;
            if (w_state_nx != HUNT) begin
                r_dout <= w_cand[w_ofs_nx];
            end
            r_comma_det <= (w_state_nx != HUNT) && w_match[w_ofs_nx];
        end
    end

    assign DOUT      = r_dout;
    assign DVALID    = (r_state != HUNT);
    assign LOCK      = (r_state == SYNC);
    assign COMMA_DET = r_comma_det;
    assign ALIGN_OFS = r_ofs;

endmodule

// File: tb/tb_comma_word_aligner.sv
// Directed bench for comma_word_aligner: expected outputs are queued per driven word and checked after each edge.
module tb_comma_word_aligner;
    localparam logic [9:0] C   = 10'b0011110101;
    localparam logic [9:0] CN  = 10'b1100001010;
    localparam logic [9:0] D35 = 10'd35;
    localparam logic [9:0] X5  = 10'b1010100111;  // repeated, yields a comma at offset 5 only
    localparam logic [9:0] H3  = 10'b0000011110;  // head of an offset-3 comma
    localparam logic [9:0] T3  = 10'b1010000000;  // tail of an offset-3 comma
    localparam logic [9:0] Y8  = 10'b1111010100;  // would match at offset 8 against reset-zero PREV

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] INP = D35;
    logic [9:0] DOUT;
    logic       DVALID, LOCK, COMMA_DET;
    logic [3:0] ALIGN_OFS;

    typedef struct {
        int         id;
        logic       v;
        logic       l;
        logic       d;
        logic [3:0] o;
        logic [9:0] dout;
        bit         cd;
    } exp_t;

    exp_t sb[$];
    exp_t e_cur;
    int   total = 0;
    int   bad = 0;
    int   step_id = 0;

    comma_word_aligner #(
        .W        (10),
        .COMMA_P  (10'b0011110101),
        .COMMA_N  (10'b1100001010),
        .LOCK_CNT (3),
        .LOSS_CNT (4)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .INP       (INP),
        .DOUT      (DOUT),
        .DVALID    (DVALID),
        .LOCK      (LOCK),
        .COMMA_DET (COMMA_DET),
        .ALIGN_OFS (ALIGN_OFS)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int id, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, id, obs, exp);
        end
    endtask

    task automatic step(input logic [9:0] inp, input logic v, input logic l, input logic d,
                        input logic [3:0] o, input logic [9:0] dout, input bit cd);
        exp_t e;
        @(negedge CLK);
        INP = inp;
        step_id++;
        e.id   = step_id;
        e.v    = v;
        e.l    = l;
        e.d    = d;
        e.o    = o;
        e.dout = dout;
        e.cd   = cd;
        sb.push_back(e);
    endtask

    always @(posedge CLK) begin
        #2;
        if (sb.size() != 0) begin
            e_cur = sb.pop_front();
            chk("dvalid", e_cur.id, 16'(DVALID), 16'(e_cur.v));
            chk("lock", e_cur.id, 16'(LOCK), 16'(e_cur.l));
            chk("comma_det", e_cur.id, 16'(COMMA_DET), 16'(e_cur.d));
            chk("align_ofs", e_cur.id, 16'(ALIGN_OFS), 16'(e_cur.o));
            if (e_cur.cd) begin
                chk("dout", e_cur.id, 16'(DOUT), 16'(e_cur.dout));
            end
        end
    end

    initial begin
        #10;
        chk("rst_dout", 0, 16'(DOUT), 16'h0);
        chk("rst_dvalid", 0, 16'(DVALID), 16'h0);
        chk("rst_lock", 0, 16'(LOCK), 16'h0);
        chk("rst_det", 0, 16'(COMMA_DET), 16'h0);
        chk("rst_ofs", 0, 16'(ALIGN_OFS), 16'h0);
        #6 reset = 1'b0;

        // idle data after reset
        repeat (20) step(D35, 0, 0, 0, 4'd0, 10'd0, 1);

        // three commas at offset 0 -> lock on the third
        step(C,   0, 0, 0, 4'd0, 10'd0, 1);
        step(D35, 1, 0, 1, 4'd0, C,     1);
        step(D35, 1, 0, 0, 4'd0, D35,   1);
        step(C,   1, 0, 0, 4'd0, D35,   1);
        step(D35, 1, 0, 1, 4'd0, C,     1);
        step(D35, 1, 0, 0, 4'd0, D35,   1);
        step(C,   1, 0, 0, 4'd0, D35,   1);
        step(D35, 1, 1, 1, 4'd0, C,     1);
        step(D35, 1, 1, 0, 4'd0, D35,   1);

        // 3 misaligned, 1 aligned, 3 misaligned: lock holds
        step(X5,  1, 1, 0, 4'd0, D35,   1);
        repeat (3) step(X5, 1, 1, 0, 4'd0, X5, 1);
        step(C,   1, 1, 0, 4'd0, X5,    1);
        step(D35, 1, 1, 1, 4'd0, C,     1);
        step(X5,  1, 1, 0, 4'd0, D35,   1);
        repeat (3) step(X5, 1, 1, 0, 4'd0, X5, 1);
        step(D35, 1, 1, 0, 4'd0, X5,    1);

        // clear the miss count, then 4 consecutive offset-5 commas drop lock
        step(C,   1, 1, 0, 4'd0, D35,   1);
        step(D35, 1, 1, 1, 4'd0, C,     1);
        step(X5,  1, 1, 0, 4'd0, D35,   1);
        repeat (3) step(X5, 1, 1, 0, 4'd0, X5, 1);
        step(X5,  0, 0, 0, 4'd0, X5,    1);
        step(D35, 0, 0, 0, 4'd0, X5,    1);

        // comma straddling a word boundary at offset 3, then lock there
        step(H3,  0, 0, 0, 4'd0, X5,    1);
        step(T3,  1, 0, 1, 4'd3, C,     1);
        step(D35, 1, 0, 0, 4'd3, 10'd0, 1);
        step(H3,  1, 0, 0, 4'd3, 10'd0, 0);
        step(T3,  1, 0, 1, 4'd3, C,     1);
        step(D35, 1, 0, 0, 4'd3, 10'd0, 1);
        step(H3,  1, 0, 0, 4'd3, 10'd0, 0);
        step(T3,  1, 1, 1, 4'd3, C,     1);
        step(D35, 1, 1, 0, 4'd3, 10'd0, 1);

        // asynchronous reset mid-lock
        @(negedge CLK);
        #1;
        chk("lock_before_rst", 0, 16'(LOCK), 16'h1);
        reset = 1'b1;
        #1;
        chk("async_lock", 0, 16'(LOCK), 16'h0);
        chk("async_dvalid", 0, 16'(DVALID), 16'h0);
        chk("async_dout", 0, 16'(DOUT), 16'h0);
        chk("async_ofs", 0, 16'(ALIGN_OFS), 16'h0);
        chk("async_det", 0, 16'(COMMA_DET), 16'h0);
        #14 reset = 1'b0;

        // first edge after release must not detect; stay in HUNT until a fresh comma
        step(Y8,  0, 0, 0, 4'd0, 10'd0, 1);
        step(D35, 0, 0, 0, 4'd0, 10'd0, 1);
        step(D35, 0, 0, 0, 4'd0, 10'd0, 1);
        step(D35, 0, 0, 0, 4'd0, 10'd0, 1);
        step(C,   0, 0, 0, 4'd0, 10'd0, 1);
        step(D35, 1, 0, 1, 4'd0, C,     1);

        // opposite-disparity comma
        @(negedge CLK);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        step(D35, 0, 0, 0, 4'd0, 10'd0, 1);
`ifdef COMMA_BOTH_RD_EN
        step(CN,  0, 0, 0, 4'd0, 10'd0, 1);
        step(D35, 1, 0, 1, 4'd0, CN,    1);
        step(D35, 1, 0, 0, 4'd0, D35,   1);
        step(CN,  1, 0, 0, 4'd0, D35,   1);
        step(D35, 1, 0, 1, 4'd0, CN,    1);
        step(D35, 1, 0, 0, 4'd0, D35,   1);
        step(CN,  1, 0, 0, 4'd0, D35,   1);
        step(D35, 1, 1, 1, 4'd0, CN,    1);
`else
        repeat (3) begin
            step(CN,  0, 0, 0, 4'd0, 10'd0, 1);
            step(D35, 0, 0, 0, 4'd0, 10'd0, 1);
            step(D35, 0, 0, 0, 4'd0, 10'd0, 1);
        end
`endif

        @(negedge CLK);
        @(negedge CLK);
        chk("sb_drained", 0, 16'(sb.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
